sram_axi_arb: RTL

Parametrised AXI4-Lite slave to single-port SRAM controller bridge, replacing the fixed 16-bit read-priority bridge. Data width, address width and an address limit are configurable. The block buffers AW, W and AR independently in one-deep holding registers and grants reads and writes round-robin, so a stream of reads cannot starve writes. Out-of-range accesses are answered with SLVERR, and an optional watchdog covers a hung SRAM core.

---
 rtl/sram_axi_arb.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_arb.sv
// sram_axi_arb: AXI4-Lite slave to single-port SRAM bridge, one-deep AW/W/AR holding slots,
// round-robin read/write grant, SLVERR on out-of-range. Define SRAM_AXI_TIMEOUT_EN for the watchdog.
module sram_axi_arb #(
  parameter int          ADDR_W         = 18,
  parameter int          DATA_W         = 16,
  parameter int unsigned ADDR_LIMIT     = 2**18,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                a_clk,
  input  logic                a_rstn,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [2:0]          aw_prot,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [1:0]          b_resp,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [2:0]          ar_prot,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                sram_req,
  input  logic                sram_ready,
  output logic                sram_rd,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_be,
  output logic [DATA_W-1:0]   sram_wr_data,
  input  logic                sram_rd_data_vld,
  input  logic [DATA_W-1:0]   sram_rd_data
);

  localparam int              BE_W  = DATA_W / 8;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(ADDR_LIMIT);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP_B, S_RESP_R} state_t;
  state_t state_reg, state_next;

  logic                aw_full_reg, aw_rdy_reg, aw_full_next;
  logic                w_full_reg, w_rdy_reg, w_full_next;
  logic                ar_full_reg, ar_rdy_reg, ar_full_next;
  logic [ADDR_W-1:0]   aw_addr_reg, ar_addr_reg;
  logic [DATA_W-1:0]   w_data_reg;
  logic [BE_W-1:0]     w_strb_reg;
  logic                last_grant_reg;
  logic                sram_rd_reg;
  logic [ADDR_W-1:0]   sram_addr_reg;
  logic [BE_W-1:0]     sram_be_reg;
  logic [DATA_W-1:0]   sram_wr_data_reg;
  logic [DATA_W-1:0]   r_data_reg;
  logic [1:0]          b_resp_reg, r_resp_reg;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, grant_rd, grant_wr, grant;
  logic wr_oor, rd_oor;
  logic rd_done, progress, timeout_hit, tmo;
  logic [BE_W-1:0] be_sel;
  logic unused_prot;

  assign unused_prot = ^{aw_prot, ar_prot};

  // Ready comes from its own register so it is low during reset and rises one edge after release.
  assign aw_ready = aw_rdy_reg;
  assign w_ready  = w_rdy_reg;
  assign ar_ready = ar_rdy_reg;

  assign aw_hs = aw_valid & aw_rdy_reg;
  assign w_hs  = w_valid & w_rdy_reg;
  assign ar_hs = ar_valid & ar_rdy_reg;

  assign wr_elig  = (state_reg == S_IDLE) & aw_full_reg & w_full_reg;
  assign rd_elig  = (state_reg == S_IDLE) & ar_full_reg;
  assign grant_rd = rd_elig & (!wr_elig | !last_grant_reg);
  assign grant_wr = wr_elig & !grant_rd;
  assign grant    = grant_rd | grant_wr;

  assign wr_oor = {1'b0, aw_addr_reg} >= LIMIT;
  assign rd_oor = {1'b0, ar_addr_reg} >= LIMIT;

  // Grant and capture never coincide on a slot: a full slot is not ready.
  assign aw_full_next = grant_wr ? 1'b0 : (aw_hs ? 1'b1 : aw_full_reg);
  assign w_full_next  = grant_wr ? 1'b0 : (w_hs ? 1'b1 : w_full_reg);
  assign ar_full_next = grant_rd ? 1'b0 : (ar_hs ? 1'b1 : ar_full_reg);

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be
      assign be_sel[gi] = grant_rd | w_strb_reg[gi];
    end
  endgenerate

  assign rd_done  = ((state_reg == S_ISSUE) & sram_ready & sram_rd_reg & sram_rd_data_vld) |
                    ((state_reg == S_WAIT_RD) & sram_rd_data_vld);
  assign progress = ((state_reg == S_ISSUE) & sram_ready) |
                    ((state_reg == S_WAIT_RD) & sram_rd_data_vld);
  assign tmo      = timeout_hit & !progress;

`ifdef SRAM_AXI_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer_reg;

  always_ff @(posedge a_clk or negedge a_rstn) begin
    if (!a_rstn) begin
      timer_reg <= '0;
    end else if (state_next == S_ISSUE && state_reg != S_ISSUE) begin
      timer_reg <= '0;
    end else if (state_reg == S_ISSUE || state_reg == S_WAIT_RD) begin
      timer_reg <= timer_reg + 16'd1;
    end
  end

  assign timeout_hit = ((state_reg == S_ISSUE) || (state_reg == S_WAIT_RD)) && (timer_reg == TMO_LAST);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge a_clk or negedge a_rstn) begin
    if (!a_rstn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (grant_rd)      state_next = rd_oor ? S_RESP_R : S_ISSUE;
        else if (grant_wr) state_next = wr_oor ? S_RESP_B : S_ISSUE;
      end
      S_ISSUE: begin
        if (sram_ready) begin
          if (!sram_rd_reg)          state_next = S_RESP_B;
          else if (sram_rd_data_vld) state_next = S_RESP_R;
          else                       state_next = S_WAIT_RD;
        end else if (tmo) begin
          state_next = sram_rd_reg ? S_RESP_R : S_RESP_B;
        end
      end
      S_WAIT_RD: if (sram_rd_data_vld || tmo) state_next = S_RESP_R;
      S_RESP_B:  if (b_ready) state_next = S_IDLE;
      S_RESP_R:  if (r_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_req = (state_reg == S_ISSUE);
    b_valid  = (state_reg == S_RESP_B);
    r_valid  = (state_reg == S_RESP_R);
  end

  always_ff @(posedge a_clk or negedge a_rstn) begin
    if (!a_rstn) begin
      aw_full_reg <= 1'b0;
      aw_rdy_reg  <= 1'b0;
      w_full_reg  <= 1'b0;
      w_rdy_reg   <= 1'b0;
      ar_full_reg <= 1'b0;
      ar_rdy_reg  <= 1'b0;
      aw_addr_reg <= '0;
      ar_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else begin
      aw_full_reg <= aw_full_next;
      aw_rdy_reg  <= !aw_full_next;
      w_full_reg  <= w_full_next;
      w_rdy_reg   <= !w_full_next;
      ar_full_reg <= ar_full_next;
      ar_rdy_reg  <= !ar_full_next;
      if (aw_hs) aw_addr_reg <= aw_addr;
      if (ar_hs) ar_addr_reg <= ar_addr;
      if (w_hs) begin
        w_data_reg <= w_data;
        w_strb_reg <= w_strb;
      end
    end
  end

  // Request payload and response registers; grant, read capture and timeout are state-exclusive.
  always_ff @(posedge a_clk or negedge a_rstn) begin
    if (!a_rstn) begin
      last_grant_reg   <= 1'b0;
      sram_rd_reg      <= 1'b0;
      sram_addr_reg    <= '0;
      sram_be_reg      <= '0;
      sram_wr_data_reg <= '0;
      r_data_reg       <= '0;
      b_resp_reg       <= RESP_OKAY;
      r_resp_reg       <= RESP_OKAY;
    end else begin
      if (grant) begin
        last_grant_reg   <= grant_rd;
        sram_rd_reg      <= grant_rd;
        sram_addr_reg    <= grant_rd ? ar_addr_reg : aw_addr_reg;
        sram_be_reg      <= be_sel;
        sram_wr_data_reg <= grant_rd ? '0 : w_data_reg;
        if (grant_rd) begin
          r_resp_reg <= rd_oor ? RESP_SLVERR : RESP_OKAY;
          r_data_reg <= '0;
        end else begin
          b_resp_reg <= wr_oor ? RESP_SLVERR : RESP_OKAY;
        end
      end
      if (rd_done) r_data_reg <= sram_rd_data;
      if (tmo) begin
        if (sram_rd_reg) begin
          r_resp_reg <= RESP_SLVERR;
          r_data_reg <= '0;
        end else begin
          b_resp_reg <= RESP_SLVERR;
        end
      end
    end
  end

  assign sram_rd      = sram_rd_reg;
  assign sram_addr    = sram_addr_reg;
  assign sram_be      = sram_be_reg;
  assign sram_wr_data = sram_wr_data_reg;
  assign r_data       = r_data_reg;
  assign b_resp       = b_resp_reg;
  assign r_resp       = r_resp_reg;

endmodule
